pipelined_adder: RTL and testbench

//  Parametrised, pipelined successor to the 8-bit combinational adder:

---
 rtl/pipelined_adder_pkg.sv | 8 +
 rtl/pipelined_adder_stage.sv | 77 +++++++
 rtl/pipelined_adder.sv | 73 +++++++
 tb/tb_pipelined_adder.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pipelined_adder_pkg.sv
// Shared helpers for the pipelined adder: signed-overflow rule used by the final stage.
package pipelined_adder_pkg;

  function automatic logic signed_overflow(input logic a_msb, input logic b_msb, input logic s_msb);
    return (a_msb == b_msb) && (s_msb != a_msb);
  endfunction

endpackage

// File: rtl/pipelined_adder_stage.sv
// One pipeline slice: adds chunk IDX of x/y with the incoming carry and registers
// the full payload (operands, partial sum, carry, overflow) under valid/advance control.
module pipelined_adder_stage
  import pipelined_adder_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8,
  parameter int IDX   = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             valid_i,
  input  logic             adv_next_i,
  input  logic [WIDTH-1:0] x_i,
  input  logic [WIDTH-1:0] y_i,
  input  logic [WIDTH-1:0] sum_i,
  input  logic             carry_i,
  output logic             valid_o,
  output logic             adv_o,
  output logic [WIDTH-1:0] x_o,
  output logic [WIDTH-1:0] y_o,
  output logic [WIDTH-1:0] sum_o,
  output logic             carry_o,
  output logic             ovf_o
);

  localparam int LSB = IDX * CHUNK;

  logic             valid_q;
  logic [WIDTH-1:0] x_q;
  logic [WIDTH-1:0] y_q;
  logic [WIDTH-1:0] sum_q;
  logic             carry_q;
  logic             ovf_q;

  logic [CHUNK:0]   add_d;
  logic [WIDTH-1:0] sum_d;
  logic             ovf_d;

  // Overflow is only meaningful in the last slice, where sum_d holds the final MSB.
  always_comb begin
    add_d = {1'b0, x_i[LSB +: CHUNK]} + {1'b0, y_i[LSB +: CHUNK]} + {{CHUNK{1'b0}}, carry_i};
    sum_d = sum_i;
    sum_d[LSB +: CHUNK] = add_d[CHUNK-1:0];
    ovf_d = signed_overflow(x_i[WIDTH-1], y_i[WIDTH-1], sum_d[WIDTH-1]);
  end

  assign adv_o = !valid_q || adv_next_i;

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= 1'b0;
      x_q     <= '0;
      y_q     <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else if (adv_o) begin
      valid_q <= valid_i;
      if (valid_i) begin
        x_q     <= x_i;
        y_q     <= y_i;
        sum_q   <= sum_d;
        carry_q <= add_d[CHUNK];
        ovf_q   <= ovf_d;
      end
    end
  end

  assign valid_o = valid_q;
  assign x_o     = x_q;
  assign y_o     = y_q;
  assign sum_o   = sum_q;
  assign carry_o = carry_q;
  assign ovf_o   = ovf_q;

endmodule

// File: rtl/pipelined_adder.sv
// Pipelined WIDTH-bit adder with valid/ready handshake: one CHUNK-bit slice per stage,
// carry rippling stage to stage; only ready is combinational (out_ready -> in_ready).
module pipelined_adder #(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic             carry_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             carry_out,
  output logic             overflow
);

  localparam int STAGES = (CHUNK > 0) ? (WIDTH / CHUNK) : 1;

  if (WIDTH < 1 || CHUNK < 1 || (WIDTH % CHUNK) != 0) begin : g_bad_params
    $error("pipelined_adder: WIDTH must be >= 1 and a multiple of CHUNK");
  end

  // Index k is the input side of stage k; index STAGES is the output of the last stage.
  logic             valid_s [0:STAGES];
  logic             adv_s   [0:STAGES];
  logic [WIDTH-1:0] x_s     [0:STAGES];
  logic [WIDTH-1:0] y_s     [0:STAGES];
  logic [WIDTH-1:0] sum_s   [0:STAGES];
  logic             carry_s [0:STAGES];
  logic             ovf_s   [1:STAGES];

  assign valid_s[0]      = in_valid;
  assign x_s[0]          = x;
  assign y_s[0]          = y;
  assign sum_s[0]        = '0;
  assign carry_s[0]      = carry_in;
  assign adv_s[STAGES]   = out_ready;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    pipelined_adder_stage #(
      .WIDTH (WIDTH),
      .CHUNK (CHUNK),
      .IDX   (k)
    ) u_stage (
      .clk        (clk),
      .reset      (reset),
      .valid_i    (valid_s[k]),
      .adv_next_i (adv_s[k+1]),
      .x_i        (x_s[k]),
      .y_i        (y_s[k]),
      .sum_i      (sum_s[k]),
      .carry_i    (carry_s[k]),
      .valid_o    (valid_s[k+1]),
      .adv_o      (adv_s[k]),
      .x_o        (x_s[k+1]),
      .y_o        (y_s[k+1]),
      .sum_o      (sum_s[k+1]),
      .carry_o    (carry_s[k+1]),
      .ovf_o      (ovf_s[k+1])
    );
  end

  assign in_ready  = adv_s[0] && !reset;
  assign out_valid = valid_s[STAGES];
  assign sum       = sum_s[STAGES];
  assign carry_out = carry_s[STAGES];
  assign overflow  = ovf_s[STAGES];

endmodule

// File: tb/tb_pipelined_adder.sv
// Self-checking bench: three adder configurations (32/8, 8/8, 16/4) checked against a
// queue-based arithmetic reference model, plus directed literal checks.
module tb_pipelined_adder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  for (genvar g = 0; g < 3; g++) begin : cfg
    localparam int W = (g == 0) ? 32 : ((g == 1) ? 8 : 16);
    localparam int C = (g == 2) ? 4 : 8;
    localparam int S = W / C;

    logic         rst  = 1'b1;
    logic         iv   = 1'b0;
    logic         ordy = 1'b0;
    logic         cin  = 1'b0;
    logic [W-1:0] xv   = '0;
    logic [W-1:0] yv   = '0;
    logic         in_ready;
    logic         out_valid;
    logic         cout;
    logic         ovf;
    logic [W-1:0] sum;
    logic         done_f = 1'b0;

    pipelined_adder #(.WIDTH(W), .CHUNK(C)) dut (
      .clk       (clk),
      .reset     (rst),
      .in_valid  (iv),
      .in_ready  (in_ready),
      .x         (xv),
      .y         (yv),
      .carry_in  (cin),
      .out_valid (out_valid),
      .out_ready (ordy),
      .sum       (sum),
      .carry_out (cout),
      .overflow  (ovf)
    );

    logic [W+1:0] expq[$];
    logic         rst_prev = 1'b0;
    logic         hold_v   = 1'b0;
    logic [W+1:0] held     = '0;
    int           stalls   = 0;

    task automatic c(input string name, input logic [63:0] act, input logic [63:0] exp);
      chk($sformatf("W%0d_C%0d_%s", W, C, name), act, exp);
    endtask

    // Reference: plain integer arithmetic, returns {overflow, carry, sum}.
    function automatic logic [W+1:0] model(input logic [W-1:0] a, input logic [W-1:0] b, input logic ci);
      longint      ua, ub, sa, sb, sv, lim;
      logic [63:0] fu;
      logic        ov;
      ua  = longint'(a);
      ub  = longint'(b);
      sa  = longint'($signed(a));
      sb  = longint'($signed(b));
      fu  = 64'(ua + ub + longint'(ci));
      sv  = sa + sb + longint'(ci);
      lim = longint'(1) << (W - 1);
      ov  = (sv >= lim) || (sv < -lim);
      return {ov, fu[W], fu[W-1:0]};
    endfunction

    always @(negedge clk) begin
      if (rst_prev)
        c("reset_outputs", 64'({out_valid, cout, ovf, sum}), 64'(0));
      if (rst) begin
        c("in_ready_in_reset", 64'(in_ready), 64'(0));
        expq.delete();
        hold_v = 1'b0;
      end else begin
        if (hold_v)
          c("stall_stable", 64'({out_valid, ovf, cout, sum}), 64'({1'b1, held}));
        if (out_valid && ordy) begin
          c("output_pending", 64'(expq.size() != 0), 64'(1));
          if (expq.size() != 0)
            c("result", 64'({ovf, cout, sum}), 64'(expq.pop_front()));
          hold_v = 1'b0;
        end else if (out_valid) begin
          hold_v = 1'b1;
          held   = {ovf, cout, sum};
        end else begin
          hold_v = 1'b0;
        end
        if (iv && in_ready)
          expq.push_back(model(xv, yv, cin));
      end
      rst_prev = rst;
    end

    task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic ci);
      int n = 0;
      xv = a; yv = b; cin = ci; iv = 1'b1;
      @(negedge clk);
      while (!in_ready && n < 200) begin
        @(negedge clk);
        n++;
      end
      c("send_timeout", 64'(n < 200), 64'(1));
      stalls += n;
      @(posedge clk); #1;
      iv = 1'b0;
    endtask

    task automatic drain();
      int n = 0;
      while (expq.size() != 0 && n < 500) begin
        @(posedge clk);
        n++;
      end
      c("drain_timeout", 64'(n < 500), 64'(1));
      #1;
    endtask

    task automatic op_check(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                            input logic ci, input logic [W-1:0] es, input logic ec, input logic eo);
      send(a, b, ci);
      if (S > 1) begin
        repeat (S - 1) @(posedge clk);
        #1;
      end
      c(name, 64'({out_valid, cout, ovf, sum}), 64'({1'b1, ec, eo, es}));
    endtask

    initial begin
      logic [W-1:0] ones, maxp, minn;
      logic [31:0]  r1, r2;
      int           acc;
      bit           took;
      ones = '1;
      maxp = {1'b0, {(W-1){1'b1}}};
      minn = {1'b1, {(W-1){1'b0}}};

      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      ordy = 1'b1;
      #0 c("in_ready_after_reset", 64'(in_ready), 64'(1));

      op_check("wrap_cin", ones, '0, 1'b1, '0, 1'b1, 1'b0);
      op_check("wrap_y1",  ones, W'(1), 1'b0, '0, 1'b1, 1'b0);
      op_check("pos_ovf",  maxp, W'(1), 1'b0, minn, 1'b0, 1'b1);
      op_check("neg_ovf",  minn, minn, 1'b0, '0, 1'b1, 1'b1);
      op_check("small",    W'(5), W'(7), 1'b1, W'(13), 1'b0, 1'b0);
      op_check("neg_one",  ones, ones, 1'b1, ones, 1'b1, 1'b0);

      // Back-to-back random stream with the consumer always ready.
      stalls = 0;
      for (int i = 0; i < 100; i++) begin
        r1 = $urandom; r2 = $urandom;
        send(r1[W-1:0], r2[W-1:0], 1'($urandom_range(0, 1)));
      end
      c("stream_no_stall", 64'(stalls), 64'(0));
      drain();

      // Fill with consumer stalled for 10 cycles.
      ordy = 1'b0;
      acc  = 0;
      r1 = $urandom; r2 = $urandom;
      xv = r1[W-1:0]; yv = r2[W-1:0]; cin = 1'($urandom_range(0, 1)); iv = 1'b1;
      for (int i = 0; i < 10; i++) begin
        @(negedge clk);
        took = in_ready;
        if (took) acc++;
        @(posedge clk); #1;
        if (took) begin
          r1 = $urandom; r2 = $urandom;
          xv = r1[W-1:0]; yv = r2[W-1:0]; cin = 1'($urandom_range(0, 1));
        end
      end
      c("fill_accepts", 64'(acc), 64'(S));
      c("full_in_ready", 64'(in_ready), 64'(0));
      c("full_out_valid", 64'(out_valid), 64'(1));
      iv   = 1'b0;
      ordy = 1'b1;
      drain();
      c("fill_queue_empty", 64'(expq.size()), 64'(0));

      // Reset with operations in flight.
      ordy = 1'b0;
      iv   = 1'b1;
      for (int i = 0; i < 3; i++) begin
        r1 = $urandom; r2 = $urandom;
        xv = r1[W-1:0]; yv = r2[W-1:0];
        @(posedge clk); #1;
      end
      iv  = 1'b0;
      rst = 1'b1;
      @(posedge clk); #1;
      c("reset_clears", 64'({out_valid, sum}), 64'(0));
      rst  = 1'b0;
      ordy = 1'b1;
      repeat (10) @(posedge clk);
      #1 c("no_stale", 64'(out_valid), 64'(0));

      // Random valid and backpressure; producer holds data until accepted.
      r1 = $urandom; r2 = $urandom;
      xv = r1[W-1:0]; yv = r2[W-1:0]; cin = 1'b0; iv = 1'b1;
      for (int i = 0; i < 300; i++) begin
        @(negedge clk);
        took = iv && in_ready;
        @(posedge clk); #1;
        if (!iv || took) begin
          r1 = $urandom; r2 = $urandom;
          xv  = r1[W-1:0]; yv = r2[W-1:0];
          cin = 1'($urandom_range(0, 1));
          iv  = ($urandom_range(0, 3) != 0);
        end
        ordy = ($urandom_range(0, 3) != 0);
      end
      iv   = 1'b0;
      ordy = 1'b1;
      drain();
      c("final_queue_empty", 64'(expq.size()), 64'(0));
      done_f = 1'b1;
    end
  end

  initial begin
    int n = 0;
    while (!(cfg[0].done_f && cfg[1].done_f && cfg[2].done_f) && n < 20000) begin
      @(posedge clk);
      n++;
    end
    chk("global_timeout", 64'(n < 20000), 64'(1));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
